regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of register-file entries.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (log2 NUM_REGS).
REQ-003 SHALL have parameter DATA_W, default 32, register data width.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero all registers after reset.
REQ-005 SHALL have parameter ZERO_GUARD, default 1; 1 = suppress writes to address 0.
REQ-006 SHALL have one clock and a synchronous, active-high reset:
  CLK  in  1  clock; all state updates on rising edge
  RST  in  1  synchronous, active-high reset
REQ-007 SHALL have the following requester ports (X = A, B):
  ReqX_Valid  in   1       write request pending
  ReqX_Addr   in   ADDR_W  target register
  ReqX_Data   in   DATA_W  write data
  ReqX_Ready  out  1       request accepted this cycle
REQ-008 SHALL have the following register-file write-port outputs:
  AWR     out  ADDR_W  write address
  DataIn  out  DATA_W  write data
  WE      out  1       write strobe, one cycle per write
REQ-009 SHALL have the following status outputs:
  Busy   out  1  clear sequence in progress
  GntB   out  1  last issued write came from B (0 = A)

Function
REQ-010 SHALL implement FSM states INIT and RUN.
REQ-011 SHALL leave reset in INIT if CLEAR_ON_RESET=1, else in RUN.
REQ-012 In INIT: SHALL issue WE=1, DataIn=0, AWR=counter for counter 0..NUM_REGS-1, one per cycle, then go to RUN; the sequence lasts exactly NUM_REGS cycles.
REQ-013 In INIT: SHALL hold Busy=1 and both ReqX_Ready=0.
REQ-014 In RUN: SHALL hold Busy=0.
REQ-015 Handshake: a transfer occurs when ReqX_Valid=1 and ReqX_Ready=1 in the same cycle.
REQ-016 Handshake: a requester SHALL hold Valid, Addr and Data stable until accepted.
REQ-017 Handshake: ReqX_Ready is combinational from the current Valids and the priority pointer, and is asserted only in RUN.
REQ-018 SHALL accept at most one request per cycle, giving throughput of one write per cycle.
REQ-019 Arbitration: a single valid requester SHALL always be granted.
REQ-020 Arbitration: when both are valid, the requester not granted most recently SHALL win (round-robin).
REQ-021 Arbitration: the priority pointer SHALL update only on an accepted transfer and SHALL favour A after reset.
REQ-022 Latency: an accepted request SHALL appear on AWR/DataIn with WE=1 exactly one cycle after acceptance; outputs are registered.
REQ-023 Latency: WE=0 in any cycle following a cycle with no transfer.
REQ-024 Address 0 with ZERO_GUARD=1: the request SHALL be accepted (Ready=1) and the pointer updated, but WE stays 0 the next cycle.
REQ-025 Same address from both requesters SHALL be issued in grant order, so the later write wins.
REQ-026 Addresses SHALL be passed through unchanged; no wrap-around or modification. The INIT counter is ADDR_W+1 bits wide to detect its terminal count.
REQ-027 GntB SHALL update together with WE=1 issues only.

Reset
REQ-028 On RST=1 at a clock edge: WE=0, AWR=0, DataIn=0, GntB=0, pointer favours A, INIT counter=0, and state is INIT if CLEAR_ON_RESET=1 else RUN.
REQ-029 During reset, Busy SHALL equal CLEAR_ON_RESET and both ReqX_Ready=0.
REQ-030 Reset mid-operation, including mid-INIT, SHALL discard any accepted-but-unissued write and restart INIT from address 0.

Structure
REQ-031 Package regfile_pkg SHALL hold NUM_REGS, ADDR_W and DATA_W defaults plus the INIT/RUN state encoding.
REQ-032 Two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs: two requests, pointer; outputs: two one-hot grants).

Verification
REQ-033 The bench SHALL cover: release RST with CLEAR_ON_RESET=1 -> Busy=1 for 32 cycles, WE=1 with AWR 0..31 and DataIn=0, then Busy=0.
REQ-034 The bench SHALL cover: in RUN, ReqA only, Addr=5, Data=0xDEADBEEF -> ReqA_Ready=1 same cycle; next cycle WE=1, AWR=5, DataIn=0xDEADBEEF, GntB=0.
REQ-035 The bench SHALL cover: A and B both held valid for 4 cycles (A: addr 1, B: addr 2) -> grants A, B, A, B; WE every cycle; AWR 1, 2, 1, 2.
REQ-036 The bench SHALL cover: ReqB Addr=0, Data=0xFFFFFFFF with ZERO_GUARD=1 -> ReqB_Ready=1; next cycle WE=0; next contested grant goes to A.
REQ-037 The bench SHALL cover: RST asserted at INIT cycle 10 -> next cycle WE=0; after release INIT restarts at AWR=0 and runs the full 32 cycles.
REQ-038 The bench SHALL cover: A and B both to addr 7 (A 0x11, B 0x22) -> two writes in grant order; register 7 ends at 0x22.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and FSM encoding for the register-file write arbiter
package regfile_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant logic
module rr_arbiter2 (
    input  logic req_a,
    input  logic req_b,
    input  logic ptr,
    output logic gnt_a,
    output logic gnt_b
);

    // ptr=0 favours A on contention, ptr=1 favours B; a lone requester always wins
    assign gnt_a = req_a & (~req_b | ~ptr);
    assign gnt_b = req_b & (~req_a |  ptr);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - arbitrates two write requesters onto one register-file write port
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGS       = NUM_REGS_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ZERO_GUARD     = 1
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              ReqA_Valid,
    input  logic [ADDR_W-1:0] ReqA_Addr,
    input  logic [DATA_W-1:0] ReqA_Data,
    output logic              ReqA_Ready,

    input  logic              ReqB_Valid,
    input  logic [ADDR_W-1:0] ReqB_Addr,
    input  logic [DATA_W-1:0] ReqB_Data,
    output logic              ReqB_Ready,

    output logic [ADDR_W-1:0] AWR,
    output logic [DATA_W-1:0] DataIn,
    output logic              WE,

    output logic              Busy,
    output logic              GntB
);

    // The clear counter carries one extra bit so its terminal value fits for any NUM_REGS
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    state_t            state;
    logic [ADDR_W:0]   init_cnt;
    logic              ptr;

    logic              gnt_a;
    logic              gnt_b;
    logic              run_ok;
    logic              xfer_a;
    logic              xfer_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_zero;

    rr_arbiter2 u_arb (
        .req_a (ReqA_Valid),
        .req_b (ReqB_Valid),
        .ptr   (ptr),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    // Requests are only accepted in RUN and never while reset is held
    assign run_ok     = (state == ST_RUN) && !RST;
    assign ReqA_Ready = run_ok & gnt_a;
    assign ReqB_Ready = run_ok & gnt_b;
    assign xfer_a     = ReqA_Valid & ReqA_Ready;
    assign xfer_b     = ReqB_Valid & ReqB_Ready;

    // During reset Busy reflects where the FSM will land once reset drops
    assign Busy = RST ? (CLEAR_ON_RESET != 0) : (state == ST_INIT);

    assign sel_addr = xfer_b ? ReqB_Addr : ReqA_Addr;
    assign sel_data = xfer_b ? ReqB_Data : ReqA_Data;
    assign sel_zero = (ZERO_GUARD != 0) && (sel_addr == '0);

    // Clear sequence, arbitration pointer and registered write-port outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_cnt <= '0;
            ptr      <= 1'b0;
            WE       <= 1'b0;
            AWR      <= '0;
            DataIn   <= '0;
            GntB     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    WE     <= 1'b1;
                    AWR    <= init_cnt[ADDR_W-1:0];
                    DataIn <= '0;
                    if (init_cnt == LAST_IDX) begin
                        state    <= ST_RUN;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    WE <= 1'b0;
                    if (xfer_a || xfer_b) begin
                        // Favour whichever side was not just served, even for a guarded write
                        ptr <= xfer_a;
                        if (!sel_zero) begin
                            WE     <= 1'b1;
                            AWR    <= sel_addr;
                            DataIn <= sel_data;
                            GntB   <= xfer_b;
                        end
                    end
                end
            endcase
        end
    end

endmodule
